// File: rtl/eco32f_arb_pkg.sv
// Shared types and constants for the eco32f two-master Wishbone arbiter.
package eco32f_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Owner encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Sole requester wins; on a tie the master that did not own the bus last wins.
    function automatic owner_t pick_winner(input logic req0, input logic req1, input owner_t last);
        if (req0 && req1) begin
            return (last == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (req1) begin
            return OWN_M1;
        end else if (req0) begin
            return OWN_M0;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/eco32f_arb_watchdog.sv
// Wait counter for stalled strobes; flags when the count reaches TIMEOUT.
module eco32f_arb_watchdog
    import eco32f_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    logic [15:0] count;

    // Clear has priority so a fired timeout restarts the wait from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == 16'(TIMEOUT));

endmodule

// File: rtl/eco32f_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between the eco32f
// instruction bus (m0) and data bus (m1), with a stalled-access watchdog.
module eco32f_wb_arbiter
    import eco32f_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    state_t state, state_n;
    owner_t owner, owner_n;
    owner_t last_owner, last_owner_n;

    logic busy, own_m1, own_cyc, own_stb, slave_resp;
    logic count_en, fire, expired;

    assign busy       = (state == BUSY);
    assign own_m1     = (owner == OWN_M1);
    assign own_cyc    = own_m1 ? m1_cyc_i : m0_cyc_i;
    assign own_stb    = own_m1 ? m1_stb_i : m0_stb_i;
    assign slave_resp = s_ack_i | s_err_i | s_rty_i;

    // A slave answer on the expiry cycle wins over the forced error.
    assign count_en = busy & own_stb & ~slave_resp;
    assign fire     = count_en & expired;

    eco32f_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .count_en(count_en),
        .clear   (~count_en | fire),
        .expired (expired)
    );

    // State, owner and round-robin history registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_M1;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
        end
    end

    // Grant from IDLE on any cyc; release when the owner's cyc is seen low.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        case (state)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_n      = BUSY;
                    owner_n      = pick_winner(m0_cyc_i, m1_cyc_i, last_owner);
                    last_owner_n = owner_n;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_n = IDLE;
                    owner_n = OWN_NONE;
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = OWN_NONE;
            end
        endcase
    end

    // Route the owner's request to the slave and the slave response back to the owner only.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_rty_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_rty_o  = 1'b0;
        grant_o   = OWN_NONE;
        timeout_o = 1'b0;
        if (busy) begin
            s_adr_o   = own_m1 ? m1_adr_i : m0_adr_i;
            s_dat_o   = own_m1 ? m1_dat_i : m0_dat_i;
            s_sel_o   = own_m1 ? m1_sel_i : m0_sel_i;
            s_we_o    = own_m1 ? m1_we_i  : m0_we_i;
            s_cti_o   = own_m1 ? m1_cti_i : m0_cti_i;
            s_bte_o   = own_m1 ? m1_bte_i : m0_bte_i;
            s_cyc_o   = own_cyc;
            s_stb_o   = own_stb & ~fire;
            m0_ack_o  = ~own_m1 & s_ack_i;
            m0_err_o  = ~own_m1 & (s_err_i | fire);
            m0_rty_o  = ~own_m1 & s_rty_i;
            m1_ack_o  = own_m1 & s_ack_i;
            m1_err_o  = own_m1 & (s_err_i | fire);
            m1_rty_o  = own_m1 & s_rty_i;
            grant_o   = owner;
            timeout_o = fire;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
